// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the input debouncer and its helpers:
//   deb_state_e       - 2-bit debouncer FSM state encoding
//   DEB_SYNC_STAGES   - default synchronizer depth
//   DEB_STABLE_CYCLES - default number of stable samples to accept a change
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      ARM_HIGH    = 2'd1,
      STABLE_HIGH = 2'd2,
      ARM_LOW     = 2'd3
   } deb_state_e;

   localparam int unsigned DEB_SYNC_STAGES   = 2;
   localparam int unsigned DEB_STABLE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// N-flop shift-chain synchronizer for bringing an asynchronous single-bit
// signal into the clk domain. All stages reset to 0.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d_i   - asynchronous input
//   q_o   - synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
   parameter int unsigned N = 2   // number of flops, 2..4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] stage_q;
   logic [N-1:0] stage_d;

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      stage_d = {stage_q[N-2:0], d_i};
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q[N-1];

endmodule : sync_chain

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Turns a raw, bouncy, asynchronous input into a clean registered level.
// The input is synchronized, then a four-state FSM with a qualification
// counter accepts a new level only after STABLE_CYCLES consecutive samples.
// Ports:
//   clk      - clock, all state on posedge
//   reset    - asynchronous active-low reset
//   a_raw_i  - raw asynchronous input
//   level_o  - debounced registered level
//   busy_o   - high while a candidate change is being qualified
//   glitch_o - one-cycle pulse when a candidate change is abandoned
// -----------------------------------------------------------------------------
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES,
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw_i,
   output logic level_o,
   output logic busy_o,
   output logic glitch_o
);

   localparam int unsigned       CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic             s;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             glitch_q, glitch_d;

   sync_chain #(
      .N (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (a_raw_i),
      .q_o   (s)
   );

   // The ARM states count samples already seen at the new value; entering
   // ARM counts the first one, so qualification completes on the
   // STABLE_CYCLES-th consecutive sample.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      glitch_d = 1'b0;
      case (state_q)
         STABLE_LOW: begin
            if (s) begin
               state_d = ARM_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ARM_HIGH: begin
            if (!s) begin
               state_d  = STABLE_LOW;
               cnt_d    = '0;
               glitch_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = STABLE_HIGH;
               level_d  = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d    = cnt_q + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               state_d = ARM_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ARM_LOW: begin
            if (s) begin
               state_d  = STABLE_HIGH;
               cnt_d    = '0;
               glitch_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = STABLE_LOW;
               level_d  = 1'b0;
               cnt_d    = '0;
            end else begin
               cnt_d    = cnt_q + CNT_ONE;
            end
         end
         default: begin
            // Unreachable encodings recover to the reset state.
            state_d = STABLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= STABLE_LOW;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         glitch_q <= glitch_d;
      end
   end

   assign level_o  = level_q;
   assign glitch_o = glitch_q;
   assign busy_o   = (state_q == ARM_HIGH) || (state_q == ARM_LOW);

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Directed bench for input_debouncer: one instance with default parameters
// (a-side) and one with SYNC_STAGES=3, STABLE_CYCLES=8 (b-side).
// Expected edge numbers count posedges after the one at which the raw input
// was driven; a step driven there is captured on the next edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

   logic clk;
   logic reset;
   logic a_raw, b_raw;
   logic level_a, busy_a, glitch_a;
   logic level_b, busy_b, glitch_b;

   int n_checks;
   int n_fail;

   input_debouncer u_dut_a (
      .clk      (clk),
      .reset    (reset),
      .a_raw_i  (a_raw),
      .level_o  (level_a),
      .busy_o   (busy_a),
      .glitch_o (glitch_a)
   );

   input_debouncer #(
      .SYNC_STAGES   (3),
      .STABLE_CYCLES (8)
   ) u_dut_b (
      .clk      (clk),
      .reset    (reset),
      .a_raw_i  (b_raw),
      .level_o  (level_b),
      .busy_o   (busy_b),
      .glitch_o (glitch_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one posedge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive pat[0..len-1] one bit per cycle (holding the last bit afterwards)
   // on the selected instance for total edges, and summarise its outputs.
   task automatic run_seq(input logic [31:0] pat, input int len, input int total,
                          input bit sel, output int n_glitch, output int n_busy,
                          output int first_busy, output int n_change,
                          output int first_change);
      logic prev, lv, bz, gl;
      prev         = sel ? level_b : level_a;
      n_glitch     = 0;
      n_busy       = 0;
      first_busy   = -1;
      n_change     = 0;
      first_change = -1;
      for (int i = 1; i <= total; i++) begin
         if (i <= len) begin
            if (sel) b_raw = pat[i-1];
            else     a_raw = pat[i-1];
         end
         step();
         lv = sel ? level_b  : level_a;
         bz = sel ? busy_b   : busy_a;
         gl = sel ? glitch_b : glitch_a;
         if (gl) n_glitch++;
         if (bz) begin
            n_busy++;
            if (first_busy < 0) first_busy = i;
         end
         if (lv !== prev) begin
            n_change++;
            if (first_change < 0) first_change = i;
            prev = lv;
         end
      end
   endtask

   initial begin
      int ng, nb, fb, nc, fc;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      a_raw    = 1'b1;
      b_raw    = 1'b0;

      // Reset held with the raw input high: outputs stay at reset values.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_level", int'(level_a), 0);
         check("rst_busy", int'(busy_a), 0);
         check("rst_glitch", int'(glitch_a), 0);
      end
      reset = 1'b1;
      run_seq(32'd1, 1, 10, 1'b0, ng, nb, fb, nc, fc);
      check("idle_rise_edge", fc, 6);
      check("idle_rise_count", nc, 1);
      check("idle_glitch", ng, 0);
      run_seq(32'd0, 1, 10, 1'b0, ng, nb, fb, nc, fc);
      check("idle_fall_edge", fc, 6);

      // Clean press and release.
      run_seq(32'd1, 1, 20, 1'b0, ng, nb, fb, nc, fc);
      check("press_busy_first", fb, 3);
      check("press_busy_cycles", nb, 3);
      check("press_rise_edge", fc, 6);
      check("press_changes", nc, 1);
      check("press_glitch", ng, 0);
      check("press_level", int'(level_a), 1);
      run_seq(32'd0, 1, 10, 1'b0, ng, nb, fb, nc, fc);
      check("release_fall_edge", fc, 6);
      check("release_busy_cycles", nb, 3);
      check("release_glitch", ng, 0);

      // Bounce 1,0,1,1,0,1,1,1,1,1: final 0->1 is driven at edge 5.
      run_seq(32'b11111_01101, 10, 16, 1'b0, ng, nb, fb, nc, fc);
      check("bounce_glitches", ng, 2);
      check("bounce_changes", nc, 1);
      check("bounce_rise_edge", fc, 11);
      check("bounce_busy_cycles", nb, 6);
      run_seq(32'd0, 1, 10, 1'b0, ng, nb, fb, nc, fc);
      check("bounce_fall_edge", fc, 6);

      // Single-cycle spike.
      run_seq(32'b01, 2, 8, 1'b0, ng, nb, fb, nc, fc);
      check("spike_busy_cycles", nb, 1);
      check("spike_glitches", ng, 1);
      check("spike_changes", nc, 0);
      check("spike_level", int'(level_a), 0);

      // Reset while qualifying a rise (ARM_HIGH, cnt=2 after edge 4).
      a_raw = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("midrst_busy_before", int'(busy_a), 1);
      reset = 1'b0;
      #1;
      check("midrst_busy_now", int'(busy_a), 0);
      check("midrst_level_now", int'(level_a), 0);
      step();
      step();
      check("midrst_busy_held", int'(busy_a), 0);
      reset = 1'b1;
      run_seq(32'd1, 1, 10, 1'b0, ng, nb, fb, nc, fc);
      check("midrst_rise_edge", fc, 6);
      check("midrst_glitch", ng, 0);
      run_seq(32'd0, 1, 10, 1'b0, ng, nb, fb, nc, fc);

      // Deeper synchronizer and longer qualification on the b-side.
      run_seq(32'd1, 1, 16, 1'b1, ng, nb, fb, nc, fc);
      check("sweep_rise_edge", fc, 11);
      check("sweep_rise_glitch", ng, 0);
      run_seq(32'd0, 1, 16, 1'b1, ng, nb, fb, nc, fc);
      check("sweep_fall_edge", fc, 11);
      run_seq(32'b0111_1111, 8, 20, 1'b1, ng, nb, fb, nc, fc);
      check("sweep_pulse_changes", nc, 0);
      check("sweep_pulse_glitches", ng, 1);
      check("sweep_pulse_busy", nb, 7);
      check("sweep_pulse_level", int'(level_b), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_input_debouncer
